parfir_mac: RTL and testbench
=============================

# parfir_mac

Parametrised PAR-sample-per-transaction FIR filter, generalising the fixed 2-parallel filter. It accepts PAR samples per input handshake and returns PAR filtered samples per output handshake. Arithmetic is time-multiplexed on a single multiply-accumulate unit, with full-precision accumulation followed by a configurable rounding shift and saturation. It sits in the streaming datapath between the sample source and sink, using the same four-phase req/ack protocol on both sides.

## Interface
- PAR, 2: samples per transaction, 1 to 8.
- NR_TAPS, 16: filter length, 1 or more.
- DWIDTH, 16: sample width, two's complement.
- CWIDTH, 16: coefficient width, two's complement.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0 to CWIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_in  output  1  block requests an input word.
- ack_in  input  1  environment: data_in valid.
- data_in  input  PAR*DWIDTH  bits [k*DWIDTH +: DWIDTH] hold sample k; sample 0 is oldest.
- req_out  output  1  data_out valid, block requests a take.
- ack_out  input  1  environment has taken data_out.
- data_out  output  PAR*DWIDTH  same packing as data_in; sample 0 is oldest.
- h_in  input  NR_TAPS*CWIDTH  h[k] = h_in[k*CWIDTH +: CWIDTH]; must be static outside reset.

## Operation
- Filter: y[n] = sum over k=0..NR_TAPS-1 of h[k]*x[n-k]. Samples before the first accepted sample are 0.
- History: a register of NR_TAPS+PAR-1 samples, zero at reset.
  - On input capture it shifts by PAR.
  - The new samples enter in order: sample PAR-1 is newest.
- Accumulator width: DWIDTH+CWIDTH+ceil(log2(NR_TAPS))+1, signed. Overflow is impossible.
- Output per sample:
  - If SHIFT>0, add 2^(SHIFT-1) (round half toward +infinity).
  - Then arithmetic shift right by SHIFT.
  - Then saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- FSM states:
  - REQ_IN: req_in=1. When ack_in=1, capture data_in, shift history, drop req_in, go to IN_REL.
  - IN_REL: wait for ack_in=0, then go to COMPUTE and clear the sample index and tap counters.
  - COMPUTE: one MAC per cycle, PAR*NR_TAPS cycles in total.
    - Samples are processed in order 0..PAR-1; taps in order 0..NR_TAPS-1.
    - After the last tap of sample j, the rounded and saturated result is written to output slot j and the accumulator is cleared.
    - After the last MAC, go to FINISH.
  - FINISH: load the staged results into data_out, set req_out=1, go to REQ_OUT.
  - REQ_OUT: when ack_out=1, drop req_out and go to OUT_REL.
  - OUT_REL: wait for ack_out=0, then go to REQ_IN.
- ack_in outside REQ_IN/IN_REL and ack_out outside REQ_OUT/OUT_REL are ignored: no state, data or history change.
- data_out holds its last value until the next FINISH.

## Timing
- Reset values:
  - req_in=0, req_out=0, data_out=0.
  - History zeroed, accumulator zeroed, FSM in REQ_IN.
- First edge after rst deasserts: req_in rises to 1.
- Input: data is captured on the first edge that sees ack_in=1 in REQ_IN; req_in=0 after that same edge.
- COMPUTE is entered on the edge that sees ack_in=0 in IN_REL.
- Latency: req_out rises PAR*NR_TAPS+1 edges after entering COMPUTE. data_out is valid in the same cycle as req_out.
- Output: req_out falls on the first edge that sees ack_out=1. req_in rises one edge after the edge that sees ack_out=0.
- ack_in held high across several cycles: exactly one capture occurs.
- rst asserted in any state: outputs go to reset values immediately, without waiting for a clock edge; history is lost.
- PAR=1, NR_TAPS=1: COMPUTE lasts 1 cycle; the block must work.

## Test plan
1. Impulse: PAR=2, NR_TAPS=4, SHIFT=0, h=1,2,3,4. Inputs (1,0),(0,0),(0,0) -> outputs (1,2),(3,4),(0,0).
2. Positive saturation: h all 0x7FFF, inputs all 0x7FFF, SHIFT=0 -> data_out=0x7FFF in both slots once history is full. Negative saturation: inputs 0x8000 -> 0x8000.
3. Rounding: SHIFT=1, h=1,0,0,0. Input (3,-3) -> (2,-1). Input (1,-1) -> (1,0).
4. Latency/handshake: PAR=2, NR_TAPS=4. req_out rises exactly 9 edges after the edge that sees ack_in=0. Delaying ack_out by 20 cycles keeps data_out stable and req_in low.
5. Spurious acks: pulse ack_in during COMPUTE and ack_out during REQ_IN -> no change to outputs, latency or subsequent results.
6. Reset mid-COMPUTE: assert rst after 3 MAC cycles -> req_in, req_out and data_out go to 0 immediately. Rerunning test 1 after reset yields identical outputs, confirming the history was cleared.

Source files
------------

// File: rtl/parfir_mac.sv
// parfir_mac: PAR-sample-per-transaction FIR on one time-multiplexed MAC, with rounding shift and saturation.
module parfir_mac #(
    parameter int PAR     = 2,
    parameter int NR_TAPS = 16,
    parameter int DWIDTH  = 16,
    parameter int CWIDTH  = 16,
    parameter int SHIFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_in,
    input  logic                       ack_in,
    input  logic [PAR*DWIDTH-1:0]      data_in,
    output logic                       req_out,
    input  logic                       ack_out,
    output logic [PAR*DWIDTH-1:0]      data_out,
    input  logic [NR_TAPS*CWIDTH-1:0]  h_in
);
    localparam int HLEN = NR_TAPS + PAR - 1;
    localparam int AW   = DWIDTH + CWIDTH + $clog2(NR_TAPS) + 1;
    localparam int JW   = PAR > 1 ? $clog2(PAR) : 1;
    localparam int TW   = NR_TAPS > 1 ? $clog2(NR_TAPS) : 1;
    localparam logic [AW:0]        ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] RND  = (ONE << SHIFT) >> 1;
    localparam logic signed [AW:0] SMAX = (ONE << (DWIDTH - 1)) - ONE;
    localparam logic signed [AW:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {REQ_IN, IN_REL, COMPUTE, FINISH, REQ_OUT, OUT_REL} state_t;

    state_t                        state, state_nxt;
    logic signed [DWIDTH-1:0]      hist [HLEN];
    logic signed [AW-1:0]          acc, sum;
    logic signed [AW:0]            rnd, shd;
    logic signed [DWIDTH-1:0]      xs;
    logic signed [CWIDTH-1:0]      hc;
    logic signed [DWIDTH+CWIDTH-1:0] prod;
    logic [DWIDTH-1:0]             sat;
    logic [PAR*DWIDTH-1:0]         stage;
    logic [JW-1:0]                 j;
    logic [TW-1:0]                 tap;
    logic                          last_tap, last_j;

    // hist[0] is the newest sample, so sample j at tap k reads hist[PAR-1-j+k]
    always_comb begin
        xs = '0;
        hc = '0;
        for (int i = 0; i < HLEN; i++)
            if (i == PAR - 1 - int'(j) + int'(tap)) xs = hist[i];
        for (int k = 0; k < NR_TAPS; k++)
            if (k == int'(tap)) hc = h_in[k*CWIDTH +: CWIDTH];
    end

    assign prod     = hc * xs;
    assign sum      = acc + AW'(prod);
    assign rnd      = (AW+1)'(sum) + RND;
    assign shd      = rnd >>> SHIFT;
    assign sat      = shd > SMAX ? SMAX[DWIDTH-1:0] : shd < SMIN ? SMIN[DWIDTH-1:0] : shd[DWIDTH-1:0];
    assign last_tap = tap == TW'(NR_TAPS - 1);
    assign last_j   = j == JW'(PAR - 1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            REQ_IN:  if (ack_in) state_nxt = IN_REL;
            IN_REL:  if (!ack_in) state_nxt = COMPUTE;
            COMPUTE: if (last_tap && last_j) state_nxt = FINISH;
            FINISH:  state_nxt = REQ_OUT;
            REQ_OUT: if (ack_out) state_nxt = OUT_REL;
            OUT_REL: if (!ack_out) state_nxt = REQ_IN;
            default: state_nxt = REQ_IN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= REQ_IN;
            req_in  <= 1'b0;
            req_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_in  <= state == REQ_IN && state_nxt == REQ_IN;
            req_out <= state_nxt == REQ_OUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HLEN; i++) hist[i] <= '0;
            acc      <= '0;
            j        <= '0;
            tap      <= '0;
            stage    <= '0;
            data_out <= '0;
        end else begin
            unique case (state)
                REQ_IN: if (ack_in) begin
                    for (int i = 0; i < PAR; i++) hist[i] <= data_in[(PAR-1-i)*DWIDTH +: DWIDTH];
                    for (int i = PAR; i < HLEN; i++) hist[i] <= hist[i-PAR];
                end
                IN_REL: if (!ack_in) begin
                    acc <= '0;
                    j   <= '0;
                    tap <= '0;
                end
                COMPUTE: if (last_tap) begin
                    acc <= '0;
                    tap <= '0;
                    j   <= j + 1'b1;
                    for (int i = 0; i < PAR; i++)
                        if (i == int'(j)) stage[i*DWIDTH +: DWIDTH] <= sat;
                end else begin
                    acc <= sum;
                    tap <= tap + 1'b1;
                end
                FINISH:  data_out <= stage;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_parfir_mac.sv
// tb_parfir_mac: scoreboard bench for parfir_mac over three configurations (2x4 shift 0, 2x4 shift 1, 1x1).
module tb_parfir_mac;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  req_in, ack_in, req_out, ack_out;
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [15:0] dout2;
    logic [63:0] h01  [2];
    logic [15:0] h2;

    int coef  [3][4];
    int par_m [3] = '{2, 2, 1};
    int tap_m [3] = '{4, 4, 1};
    int shf_m [3] = '{0, 1, 0};
    int hist_m [3][$];
    logic [31:0] exp_q [3][$];
    int n_vec = 0;
    int n_bad = 0;

    parfir_mac #(.PAR(2), .NR_TAPS(4), .DWIDTH(16), .CWIDTH(16), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_in(req_in[0]), .ack_in(ack_in[0]), .data_in(din[0]),
        .req_out(req_out[0]), .ack_out(ack_out[0]), .data_out(dout[0]), .h_in(h01[0]));
    parfir_mac #(.PAR(2), .NR_TAPS(4), .DWIDTH(16), .CWIDTH(16), .SHIFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_in(req_in[1]), .ack_in(ack_in[1]), .data_in(din[1]),
        .req_out(req_out[1]), .ack_out(ack_out[1]), .data_out(dout[1]), .h_in(h01[1]));
    parfir_mac #(.PAR(1), .NR_TAPS(1), .DWIDTH(16), .CWIDTH(16), .SHIFT(0)) u_dut2 (
        .clk(clk), .rst(rst), .req_in(req_in[2]), .ack_in(ack_in[2]), .data_in(din[2][15:0]),
        .req_out(req_out[2]), .ack_out(ack_out[2]), .data_out(dout2), .h_in(h2));
    assign dout[2] = {16'h0, dout2};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b);
        return {16'(b), 16'(a)};
    endfunction

    // reference: direct convolution over every sample accepted since reset
    function automatic logic [31:0] model(input int s, input logic [31:0] w);
        logic [31:0] r = '0;
        for (int j = 0; j < par_m[s]; j++) hist_m[s].push_back(int'($signed(w[j*16 +: 16])));
        for (int j = 0; j < par_m[s]; j++) begin
            int n = hist_m[s].size() - par_m[s] + j;
            longint a = 0;
            for (int k = 0; k < tap_m[s]; k++)
                if (n - k >= 0) a += longint'(coef[s][k]) * longint'(hist_m[s][n-k]);
            if (shf_m[s] > 0) a += longint'(1) << (shf_m[s] - 1);
            a = a >>> shf_m[s];
            if (a > 32767) a = 32767;
            if (a < -32768) a = -32768;
            r[j*16 +: 16] = 16'(a);
        end
        return r;
    endfunction

    task automatic apply_h();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 4; k++) h01[s][k*16 +: 16] = 16'(coef[s][k]);
        h2 = 16'(coef[2][0]);
    endtask

    task automatic clear_models();
        for (int s = 0; s < 3; s++) begin
            hist_m[s].delete();
            exp_q[s].delete();
        end
    endtask

    task automatic wait_bit(input int s, input bit is_out, input bit lvl, input string tag);
        for (int i = 0; i < 200 && (is_out ? req_out[s] : req_in[s]) != lvl; i++) @(negedge clk);
        check(tag, is_out ? req_out[s] : req_in[s], lvl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        apply_h();
        clear_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic xact(input int s, input logic [31:0] w, input int hold, input bit spur);
        int lat;
        logic [31:0] d0;
        bit ok;
        wait_bit(s, 0, 1, "req_in_up");
        din[s] = w;
        exp_q[s].push_back(model(s, w));
        ack_in[s] = 1'b1;
        wait_bit(s, 0, 0, "req_in_dn");
        ack_in[s] = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        while (!req_out[s] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            ack_in[s] = spur && lat == 3;
        end
        ack_in[s] = 1'b0;
        check("latency", lat, par_m[s] * tap_m[s] + 1);
        @(negedge clk);
        d0 = dout[s];
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            ok = ok && dout[s] == d0 && !req_in[s] && req_out[s];
        end
        if (hold > 0) check("hold_stable", ok, 1);
        check("data_out", dout[s], exp_q[s].pop_front());
        ack_out[s] = 1'b1;
        wait_bit(s, 1, 0, "req_out_dn");
        ack_out[s] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ack_in = '0;
        ack_out = '0;
        for (int s = 0; s < 3; s++) din[s] = '0;
        coef[0] = '{1, 2, 3, 4};
        coef[1] = '{1, 0, 0, 0};
        coef[2] = '{3, 0, 0, 0};
        apply_h();
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_req_in", req_in[s], 0);
            check("rst_req_out", req_out[s], 0);
            check("rst_data_out", dout[s], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("req_in_first_edge", req_in[0], 1);

        xact(0, pk(1, 0), 0, 0);
        xact(0, pk(0, 0), 0, 0);
        xact(0, pk(0, 0), 0, 0);

        xact(1, pk(3, -3), 0, 0);
        xact(1, pk(1, -1), 0, 0);

        xact(2, pk(5, 0), 0, 0);
        xact(2, pk(-7, 0), 0, 0);

        xact(0, pk(7, -2), 20, 0);

        wait_bit(0, 0, 1, "req_in_up");
        ack_out[0] = 1'b1;
        repeat (2) @(negedge clk);
        ack_out[0] = 1'b0;
        check("spur_ack_out_req_out", req_out[0], 0);
        check("spur_ack_out_req_in", req_in[0], 1);
        xact(0, pk(100, -50), 0, 1);
        xact(0, pk(-9, 11), 0, 0);

        wait_bit(0, 0, 1, "req_in_up");
        din[0] = pk(5, 6);
        ack_in[0] = 1'b1;
        wait_bit(0, 0, 0, "req_in_dn");
        ack_in[0] = 1'b0;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_req_in", req_in[0], 0);
        check("midrst_req_out", req_out[0], 0);
        check("midrst_data_out", dout[0], 0);
        clear_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xact(0, pk(1, 0), 0, 0);
        xact(0, pk(0, 0), 0, 0);
        xact(0, pk(0, 0), 0, 0);

        coef[0] = '{32767, 32767, 32767, 32767};
        do_reset();
        repeat (3) xact(0, pk(32767, 32767), 0, 0);
        check("pos_sat", dout[0], 32'h7FFF7FFF);
        repeat (3) xact(0, pk(-32768, -32768), 0, 0);
        check("neg_sat", dout[0], 32'h80008000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
